// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the instruction encoder and the control decoder.
// Contents: opcode constants, error codes, 8-bit immediate range limits,
// the encoder state type and an immediate range helper.
package cpu_isa_pkg;

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_COMP = 4'h6;
  localparam logic [3:0] OP_COPY = 4'h7;
  localparam logic [3:0] OP_CPYC = 4'h8;
  localparam logic [3:0] OP_LOAD = 4'h9;
  localparam logic [3:0] OP_STOR = 4'hA;
  localparam logic [3:0] OP_PUSH = 4'hB;
  localparam logic [3:0] OP_POP  = 4'hC;
  localparam logic [3:0] OP_JMPL = 4'hD;
  localparam logic [3:0] OP_JMPE = 4'hE;
  localparam logic [3:0] OP_JUMP = 4'hF;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_IMM_RANGE = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;

  localparam int IMM8_MIN = -128;
  localparam int IMM8_MAX = 127;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WRITE,
    S_DONE,
    S_ERROR
  } enc_state_t;

  // True when the 10-bit signed immediate fits the 8-bit field.
  function automatic logic imm_fits8(input logic [9:0] imm);
    int v;
    v = int'($signed(imm));
    return (v >= IMM8_MIN) && (v <= IMM8_MAX);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational field packer.
// Inputs : i_opcode, i_rd, i_rx, i_ry, i_imm (10b), i_immmode
// Outputs: o_word = {opcode, payload[11:0]}, o_legal (0 when an addi/cpyc
//          immediate does not fit in 8 signed bits)
module instr_pack
  import cpu_isa_pkg::*;
(
  input  logic [3:0]  i_opcode,
  input  logic [3:0]  i_rd,
  input  logic [3:0]  i_rx,
  input  logic [3:0]  i_ry,
  input  logic [9:0]  i_imm,
  input  logic        i_immmode,
  output logic [15:0] o_word,
  output logic        o_legal
);

  logic [11:0] w_payload;

  always_comb begin
    w_payload = '0;
    o_legal   = 1'b1;
    case (i_opcode)
      OP_AND, OP_OR, OP_ADD, OP_SUB:      w_payload = {i_rd, i_rx, i_ry};
      OP_ADDI, OP_CPYC: begin
        w_payload = {i_imm[7:0], i_rd};
        o_legal   = imm_fits8(i_imm);
      end
      OP_COMP, OP_COPY, OP_LOAD, OP_STOR: w_payload = {4'h0, i_rx, i_ry};
      OP_PUSH:                            w_payload = {8'h00, i_ry};
      OP_POP:                             w_payload = {8'h00, i_rd};
      // Immediate jumps carry a marker bit 11 so the decoder can tell them apart.
      OP_JMPL, OP_JMPE, OP_JUMP:
        w_payload = i_immmode ? {2'b10, i_imm} : {8'h00, i_ry};
      OP_HALT:                            w_payload = '0;
      default:                            w_payload = '0;
    endcase
  end

  assign o_word = {i_opcode, w_payload};

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts field-level instructions over valid/ready, packs
// them and writes them to instruction memory at sequential addresses.
// Ports: clk, rst_n (async active-low); start/abort/base_addr session control;
//        in_valid/in_ready + in_* instruction fields; mem_we/mem_addr/mem_wdata
//        memory write port; busy/done/err/err_code/word_count status.
// Optional: `define INSTR_ENCODER_CHECKSUM_EN adds checksum[15:0], the running
//           XOR of every word written in the current session.
module instr_encoder
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rx,
  input  logic [3:0]        in_ry,
  input  logic [9:0]        in_imm,
  input  logic              in_immmode,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
`ifdef INSTR_ENCODER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  if (WORD_W != 16) begin : g_word_w_check
    $error("instr_encoder: WORD_W must be 16");
  end

  enc_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_word;
  logic [1:0]        r_err_code;
  logic [ADDR_W:0]   r_word_count;
  logic [15:0]       w_word;
  logic              w_legal;
`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [15:0]       r_checksum;
`endif

  instr_pack u_pack (
    .i_opcode (in_opcode),
    .i_rd     (in_rd),
    .i_rx     (in_rx),
    .i_ry     (in_ry),
    .i_imm    (in_imm),
    .i_immmode(in_immmode),
    .o_word   (w_word),
    .o_legal  (w_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_word       <= '0;
      r_err_code   <= ERR_NONE;
      r_word_count <= '0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
      r_checksum   <= '0;
`endif
    end else if (abort) begin
      r_state    <= S_IDLE;
      r_err_code <= ERR_NONE;
`ifdef INSTR_ENCODER_CHECKSUM_EN
      r_checksum <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state      <= S_RUN;
            r_addr       <= base_addr;
            r_word_count <= '0;
            r_err_code   <= ERR_NONE;
`ifdef INSTR_ENCODER_CHECKSUM_EN
            r_checksum   <= '0;
`endif
          end
        end
        S_RUN: begin
          if (in_valid) begin
            if (w_legal) begin
              r_word  <= w_word;
              r_state <= S_WRITE;
            end else begin
              r_err_code <= ERR_IMM_RANGE;
              r_state    <= S_ERROR;
            end
          end
        end
        S_WRITE: begin
          r_word_count <= r_word_count + (ADDR_W+1)'(1);
`ifdef INSTR_ENCODER_CHECKSUM_EN
          r_checksum   <= r_checksum ^ r_word;
`endif
          // The opcode nibble of the stored word identifies a halt.
          if (r_word[15:12] == OP_HALT) begin
            r_state <= S_DONE;
          end else if (r_addr == '1) begin
            r_err_code <= ERR_OVERFLOW;
            r_state    <= S_ERROR;
          end else begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == S_RUN);
  // abort suppresses the pending write in the same cycle.
  assign mem_we     = (r_state == S_WRITE) && !abort;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_word;
  assign busy       = (r_state == S_RUN) || (r_state == S_WRITE);
  assign done       = (r_state == S_DONE);
  assign err        = (r_state == S_ERROR);
  assign err_code   = r_err_code;
  assign word_count = r_word_count;
`ifdef INSTR_ENCODER_CHECKSUM_EN
  assign checksum   = r_checksum;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = '0, in_rd = '0, in_rx = '0, in_ry = '0;
  logic [9:0]  in_imm = '0;
  logic        in_immmode = 1'b0;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [10:0] word_count;
`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [15:0] checksum;
  logic [15:0] exp_cks = '0;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [25:0] sb[$];
  logic [9:0]  exp_addr = '0;

  instr_encoder #(.ADDR_W(10), .WORD_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rx(in_rx), .in_ry(in_ry), .in_imm(in_imm), .in_immmode(in_immmode),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .err(err), .err_code(err_code), .word_count(word_count)
`ifdef INSTR_ENCODER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every memory write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: actual=%h@%h required=none", mem_wdata, mem_addr);
      end else begin
        logic [25:0] e;
        e = sb.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          n_bad++;
          $display("FAIL write: actual=%h@%h required=%h@%h",
                   mem_wdata, mem_addr, e[15:0], e[25:16]);
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [9:0] b);
    start = 1'b1;
    base_addr = b;
    step(1);
    start = 1'b0;
    exp_addr = b;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    exp_cks = '0;
`endif
    chk("start_ready", in_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_flags", {done, err, err_code}, 0);
    chk("start_wc", word_count, 0);
  endtask

  // Handshake one instruction; returns at posedge+1 after acceptance.
  task automatic hs(input logic [3:0] op, rd, rx, ry, input logic [9:0] imm,
                    input logic mode);
    int k = 0;
    while (!in_ready && k < 8) begin
      step(1);
      k++;
    end
    if (!in_ready) begin
      chk("hs_ready_timeout", 0, 1);
      return;
    end
    in_opcode = op; in_rd = rd; in_rx = rx; in_ry = ry;
    in_imm = imm; in_immmode = mode;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, rd, rx, ry, input logic [9:0] imm,
                      input logic mode, input logic wr, input logic [15:0] word);
    if (wr) begin
      sb.push_back({exp_addr, word});
      exp_addr = exp_addr + 10'd1;
`ifdef INSTR_ENCODER_CHECKSUM_EN
      exp_cks = exp_cks ^ word;
`endif
    end
    hs(op, rd, rx, ry, imm, mode);
    chk("latency_we", mem_we, wr);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ctrl", {in_ready, mem_we, busy, done, err, err_code}, 0);
    chk("rst_data", {word_count, mem_addr, mem_wdata}, 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("idle_ready", in_ready, 0);

    // Session 1: add, addi -1, then illegal addi 200
    do_start(10'h000);
    send(4'h3, 4'd3, 4'd1, 4'd2, 10'd0, 1'b0, 1'b1, 16'h3312);
    step(1);
    chk("wc_1", word_count, 1);
    send(4'h5, 4'd5, 4'd0, 4'd0, 10'h3FF, 1'b0, 1'b1, 16'h5FF5);
    step(1);
    chk("wc_2", word_count, 2);
`ifdef INSTR_ENCODER_CHECKSUM_EN
    chk("checksum", checksum, exp_cks);
`endif
    send(4'h5, 4'd5, 4'd0, 4'd0, 10'd200, 1'b0, 1'b0, 16'h0000);
    chk("imm_err", {err, err_code}, {1'b1, 2'd1});
    chk("imm_wc", word_count, 2);
    chk("imm_busy", {busy, in_ready}, 0);

    // Session 2: jumps, push, pop, sub, halt
    do_start(10'h010);
    send(4'hE, 4'd0, 4'd0, 4'd0, 10'h155, 1'b1, 1'b1, 16'hE955);
    send(4'hF, 4'd0, 4'd0, 4'd7, 10'h155, 1'b0, 1'b1, 16'hF007);
    send(4'hB, 4'd1, 4'd2, 4'd4, 10'd0, 1'b0, 1'b1, 16'hB004);
    send(4'hC, 4'd9, 4'd2, 4'd4, 10'd0, 1'b0, 1'b1, 16'hC009);
    send(4'h4, 4'd1, 4'd2, 4'd3, 10'd0, 1'b0, 1'b1, 16'h4123);
    send(4'h0, 4'd1, 4'd2, 4'd3, 10'h3FF, 1'b1, 1'b1, 16'h0000);
    step(1);
    chk("halt_wc", word_count, 6);
    for (int i = 0; i < 5; i++) begin
      chk("done_hold", {done, err, in_ready, busy}, 4'b1000);
      step(1);
    end

    // Session 3: overflow at top of memory
    do_start(10'h3FE);
    send(4'h7, 4'd0, 4'd1, 4'd2, 10'd0, 1'b0, 1'b1, 16'h7012);
    step(1);
    send(4'h7, 4'd0, 4'd1, 4'd2, 10'd0, 1'b0, 1'b1, 16'h7012);
    step(1);
    chk("ovf_err", {err, err_code}, {1'b1, 2'd2});
    chk("ovf_wc", word_count, 2);

    // Session 4: halt at the top address completes
    do_start(10'h3FF);
    send(4'h0, 4'd0, 4'd0, 4'd0, 10'd0, 1'b0, 1'b1, 16'h0000);
    step(1);
    chk("top_halt", {done, err, err_code}, 4'b1000);

    // Abort in WRITE suppresses the write
    do_start(10'h020);
    hs(4'h3, 4'd1, 4'd1, 4'd1, 10'd0, 1'b0);
    abort = 1'b1;
    #1;
    chk("abort_we", mem_we, 0);
    step(1);
    abort = 1'b0;
    chk("abort_idle", {busy, done, err, in_ready, err_code}, 0);
    chk("abort_wc", word_count, 0);

    // start and abort together: abort wins
    start = 1'b1; abort = 1'b1;
    step(1);
    start = 1'b0; abort = 1'b0;
    chk("start_abort", {busy, in_ready}, 0);

    // Reset during a write drops everything at once
    do_start(10'h030);
    hs(4'h1, 4'd2, 4'd3, 4'd4, 10'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", {mem_we, busy, in_ready, done, err}, 0);
    chk("rst_mid_data", {word_count, mem_addr, mem_wdata}, 0);
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
